// File: rtl/mips_pkg.sv
// Shared types for the memory arbiter: FSM state and access owner encodings.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (instr/data) arbiter onto a single memory port, with a
// round-robin grant, a bus timeout and a one-cycle response phase.
module mem_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rd_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_rd_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  arb_state_t  r_state;
  arb_owner_t  r_owner;
  logic [31:0] r_addr;
  logic        r_rd_wr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_cnt;
  logic        r_err;
  logic        r_gnt_i;
  logic        r_gnt_d;

  logic        w_pick_d;
  logic        w_i_resp;
  logic        w_d_resp;

  // Equal last-grant flags means nothing has been granted since reset.
  always_comb begin
    w_pick_d = d_req;
    if (i_req && d_req) begin
      if (r_gnt_i == r_gnt_d) w_pick_d = DATA_FIRST;
      else                    w_pick_d = r_gnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= OWN_I;
      r_addr  <= '0;
      r_rd_wr <= 1'b1;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_gnt_i <= 1'b0;
      r_gnt_d <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req || d_req) begin
            r_gnt_d <= w_pick_d;
            r_gnt_i <= ~w_pick_d;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= BUSY;
            if (w_pick_d) begin
              r_owner <= OWN_D;
              r_addr  <= d_addr;
              r_rd_wr <= d_rd_wr;
              r_wdata <= d_wdata;
            end else begin
              r_owner <= OWN_I;
              r_addr  <= i_addr;
              r_rd_wr <= 1'b1;
              r_wdata <= '0;
            end
          end
        end
        BUSY: begin
          // An ack arriving on the final counted cycle still wins over the abort.
          if (mem_ack) begin
            r_rdata <= r_rd_wr ? mem_rdata : '0;
            r_err   <= 1'b0;
            r_state <= RESP;
          end else if (r_cnt == TMO_LAST) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_i_resp  = (r_state == RESP) && (r_owner == OWN_I);
  assign w_d_resp  = (r_state == RESP) && (r_owner == OWN_D);

  assign i_done    = w_i_resp;
  assign d_done    = w_d_resp;
  assign i_rdata   = w_i_resp ? r_rdata : '0;
  assign d_rdata   = w_d_resp ? r_rdata : '0;
  assign err       = (r_state == RESP) && r_err;

  assign mem_req   = (r_state == BUSY);
  assign mem_rd_wr = r_rd_wr;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, reset corner cases and
// randomized transactions against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_rd_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_req;
  logic        mem_rd_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TMO), .DATA_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mem_req(mem_req), .mem_rd_wr(mem_rd_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic        ir;
    logic        dr;
    logic        rdwr;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] rd;
    int          delay;      // BUSY cycle index carrying mem_ack; >= TMO means never
    logic        exp_d;      // 1 = data requester expected to win
    logic [31:0] exp_addr;
    logic        exp_rdwr;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle
  // cycle that follows the response.
  task automatic run_txn(input vec_t v);
    int busy;
    i_req     = v.ir;
    d_req     = v.dr;
    i_addr    = v.ia;
    d_addr    = v.da;
    d_rd_wr   = v.rdwr;
    d_wdata   = v.wd;
    mem_ack   = 1'b1;               // stray ack while idle must be ignored
    mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("grant_latency", {31'b0, mem_req}, 32'd1);
    busy = 0;
    while (mem_req && busy < 20) begin
      chk("mem_addr", mem_addr, v.exp_addr);
      chk("mem_rd_wr", {31'b0, mem_rd_wr}, {31'b0, v.exp_rdwr});
      chk("mem_wdata", mem_wdata, v.exp_wdata);
      chk("no_done_busy", {30'b0, i_done, d_done}, 32'd0);
      if (busy == v.delay) begin
        mem_ack   = 1'b1;
        mem_rdata = v.rd;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      busy++;
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk("busy_cycles", busy, v.exp_busy);
    chk("done_pair", {30'b0, i_done, d_done}, v.exp_d ? 32'd1 : 32'd2);
    chk("err", {31'b0, err}, {31'b0, v.exp_err});
    if (v.exp_d) chk("d_rdata", d_rdata, v.exp_rdata);
    else         chk("i_rdata", i_rdata, v.exp_rdata);
    if (v.exp_d) d_req = 1'b0;
    else         i_req = 1'b0;
    mem_ack   = 1'b1;               // stray ack in RESP must be ignored
    mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_gap", {29'b0, mem_req, i_done, d_done}, 32'd0);
  endtask

  // Reference model state: 0 = no grant since reset, 1 = instr, 2 = data.
  int          m_last;
  logic        m_pi, m_pd;
  logic [31:0] m_ia, m_da, m_wd;
  logic        m_rw;

  task automatic model_txn(input int delay, input logic [31:0] rd, output vec_t v);
    logic win_d;
    if (m_pi && m_pd) win_d = (m_last != 2);
    else              win_d = m_pd;
    v.ir = m_pi;  v.dr = m_pd;  v.rdwr = m_rw;
    v.ia = m_ia;  v.da = m_da;  v.wd = m_wd;
    v.rd = rd;    v.delay = delay;
    v.exp_d     = win_d;
    v.exp_addr  = win_d ? m_da : m_ia;
    v.exp_rdwr  = win_d ? m_rw : 1'b1;
    v.exp_wdata = win_d ? m_wd : 32'd0;
    v.exp_err   = (delay >= TMO);
    v.exp_rdata = (delay >= TMO || (win_d && !m_rw)) ? 32'd0 : rd;
    v.exp_busy  = (delay >= TMO) ? TMO : delay + 1;
    m_last = win_d ? 2 : 1;
    if (win_d) m_pd = 1'b0;
    else       m_pi = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0040_0000, 32'h1001_0000, 32'hDEAD_BEEF, 32'h5555_5555, 1,
                1'b1, 32'h1001_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 2};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0040_0000, 32'h1001_0004, 32'h1111_1111, 32'h2408_000A, 2,
                1'b0, 32'h0040_0000, 1'b1, 32'h0, 1'b0, 32'h2408_000A, 3};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0040_0000, 32'h1001_0004, 32'h1111_1111, 32'h7777_7777, 9,
                1'b1, 32'h1001_0004, 1'b1, 32'h1111_1111, 1'b1, 32'h0, 4};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0040_0004, 32'h0, 32'h0, 32'h1234_5678, 3,
                1'b0, 32'h0040_0004, 1'b1, 32'h0, 1'b0, 32'h1234_5678, 4};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h1001_0008, 32'h2222_2222, 32'hCAFE_F00D, 0,
                1'b1, 32'h1001_0008, 1'b1, 32'h2222_2222, 1'b0, 32'hCAFE_F00D, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0040_0008, 32'h0, 32'h0, 32'h9999_9999, 9,
                1'b0, 32'h0040_0008, 1'b1, 32'h0, 1'b1, 32'h0, 4};

    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_rd_wr = 1'b1;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_rd_wr", {31'b0, mem_rd_wr}, 32'd1);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_done", {29'b0, i_done, d_done, err}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);

    for (int k = 0; k < 6; k++) run_txn(vecs[k]);

    // Reset in the middle of a data access, then a simultaneous pair.
    d_req = 1'b1; d_rd_wr = 1'b1; d_addr = 32'h1002_0000; d_wdata = 32'h3333_3333;
    @(negedge clk);
    chk("mid_busy", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1; d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_done", {30'b0, i_done, d_done}, 32'd0);
    @(negedge clk);
    chk("mid_rst_quiet", {29'b0, mem_req, i_done, d_done}, 32'd0);

    m_last = 0;
    m_pi = 1'b1; m_pd = 1'b1;
    m_ia = 32'h0040_0100; m_da = 32'h1003_0000; m_wd = 32'h4444_4444; m_rw = 1'b1;
    model_txn(1, 32'hABCD_0001, v);
    chk("post_rst_winner", {31'b0, v.exp_d}, 32'd1);
    run_txn(v);
    model_txn(0, 32'hABCD_0002, v);
    run_txn(v);

    for (int n = 0; n < 60; n++) begin
      if (!m_pi && ($urandom_range(0, 1) == 1)) begin
        m_pi = 1'b1;
        m_ia = {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} | 32'(n << 2);
      end
      if (!m_pd && ($urandom_range(0, 1) == 1)) begin
        m_pd = 1'b1;
        m_da = $urandom;
        m_wd = $urandom;
        m_rw = 1'($urandom_range(0, 1));
      end
      if (!m_pi && !m_pd) begin
        m_pd = 1'b1;
        m_da = $urandom;
        m_wd = $urandom;
        m_rw = 1'b0;
      end
      model_txn($urandom_range(0, 6), $urandom, v);
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles in BUSY awaiting mem_ack before abort (range 2..255).
REQ-002 Parameter: DATA_FIRST, 1, winner on a simultaneous request when both last-grant flags are equal (1 = data, 0 = instr).
REQ-003 Clock and reset: reset reset, synchronous, active-high; clock clk.
REQ-004 Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- i_req  in  1  instr fetch request, level, held until i_done
- i_addr  in  32  instr address
- i_done  out  1  one-cycle completion pulse to instr requester
- i_rdata  out  32  fetched word, valid while i_done=1
- d_req  in  1  data request, level, held until d_done
- d_rd_wr  in  1  1 = read, 0 = write
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_done  out  1  one-cycle completion pulse to data requester
- d_rdata  out  32  load word, valid while d_done=1
- err  out  1  high with the done pulse when the access timed out
- mem_req  out  1  memory access strobe, held until mem_ack or abort
- mem_rd_wr  out  1  1 = read, 0 = write
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, sampled on mem_ack
- mem_ack  in  1  memory completion, one cycle

Function
REQ-005 FSM states: IDLE, BUSY, RESP; encoding lives in the package.
REQ-006 IDLE: no request -> stay; any request -> pick a winner, register owner, address, rd_wr, wdata, go BUSY.
REQ-007 Arbitration: only one requester -> it wins; both -> the requester not granted last wins; no previous grant since reset -> DATA_FIRST decides.
REQ-008 Instr accesses: mem_rd_wr=1, mem_wdata=0.
REQ-009 BUSY: mem_req=1 with registered mem_rd_wr/mem_addr/mem_wdata stable; mem_ack -> capture mem_rdata, go RESP.
REQ-010 BUSY timeout counter: cleared on BUSY entry, increments each BUSY cycle; reaches TIMEOUT without mem_ack -> drop mem_req, set err flag, captured data = 0, go RESP.
REQ-011 mem_ack in the same cycle the counter reaches TIMEOUT -> counts as success, err=0.
REQ-012 RESP: exactly one cycle; owner's done=1 with its rdata (write: rdata=0); err as flagged; next state IDLE.
REQ-013 Requests are not sampled in BUSY or RESP; the requester deasserts req in the cycle after done. A request still high in IDLE is a new access.
REQ-014 Minimum latency: request in IDLE at cycle 0, mem_ack at cycle 1 -> done at cycle 2; next grant at cycle 3.
REQ-015 mem_ack outside BUSY is ignored.
REQ-016 Non-owner done is always 0; i_done and d_done are never both 1.
REQ-017 All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

Reset
REQ-018 Reset -> IDLE; mem_req=0, mem_rd_wr=1, mem_addr=0, mem_wdata=0, i_done=d_done=0, i_rdata=d_rdata=0, err=0, counter=0, last-grant flags cleared.
REQ-019 Reset mid-access aborts it silently: no done pulse, and mem_req=0 in the first cycle after reset.

Structure
REQ-020 Shared package mips_pkg holds arb_state_t (IDLE/BUSY/RESP) and arb_owner_t (OWN_I/OWN_D); TIMEOUT stays a module parameter.
REQ-021 Single module; the timeout counter and round-robin pointer are inline. No sub-module.

Verification
REQ-022 Instr only: i_addr=0x400000, mem_rdata=0x2408000A with ack at BUSY+2 -> mem_addr=0x400000, mem_rd_wr=1, i_done one cycle later with i_rdata=0x2408000A, err=0.
REQ-023 Data write: d_rd_wr=0, d_addr=0x10010000, d_wdata=0xDEADBEEF -> mem_rd_wr=0 with those values held until ack; d_done=1, d_rdata=0.
REQ-024 Simultaneous i_req and d_req after reset (DATA_FIRST=1) -> data served first, then instr; a second simultaneous pair -> instr first (alternation).
REQ-025 No ack, TIMEOUT=4 -> mem_req high exactly 4 cycles, then done with err=1 and rdata=0.
REQ-026 Reset asserted during BUSY -> mem_req=0 next cycle, no done pulse, the next grant follows the DATA_FIRST rule.
